// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer that shares one UART transmitter among
//   NUM_REQ byte sources. Accepts one byte at a time, issues a one-cycle start
//   pulse, follows the transmitter busy flag through the frame, then enforces
//   an inter-frame gap. A frame whose busy flag never appears is abandoned
//   after START_TIMEOUT clocks and flagged on timeout_err.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   req_valid    per-requester byte pending
//   req_data     packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-hot accept strobe (combinational, IDLE only)
//   tx_start     one-cycle start pulse to the UART
//   tx_data      byte to the UART, held from accept until the next accept
//   tx_busy      UART transmitter busy
//   grant_id     index of the last accepted requester
//   active       high whenever the sequencer is not idle
//   timeout_err  one-cycle pulse when a start is abandoned
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tx_start,
    output logic [DATA_WIDTH-1:0]           tx_data,
    input  logic                            tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            active,
    output logic                            timeout_err
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TMAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    tx_start_q, tx_start_d;
    logic                    active_q, active_d;
    logic                    timeout_err_q, timeout_err_d;

    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];
    logic [ID_W-1:0]         sel;
    logic                    found;
    logic                    accept;

    // Round-robin pick: first valid requester after the last winner, with wrap.
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign accept = (state_q == IDLE) && !tx_busy && found;

    // Gated by reset so nothing is offered while reset is held low.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && reset && (sel == ID_W'(i));
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        timer_d       = timer_q;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d  = req_bytes[sel];
                    grant_id_d = sel;
                    rr_ptr_d   = sel;
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy in the final cycle wins over the timeout.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    timer_d       = '0;
                    state_d       = GAP;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    timer_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            timer_q       <= '0;
            tx_start_q    <= 1'b0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            timer_q       <= timer_d;
            tx_start_q    <= tx_start_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized phase.
// A monitor predicts each winner from the round-robin rule, queues the
// expected (id, byte) and checks it when tx_start appears.
module tb_uart_tx_arbiter;

    localparam int NUM = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic        busy_model;
    logic        busy_force;
    logic        busy_auto;
    logic        busy_rand;
    int          busy_dly;
    int          busy_len;

    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t        exp_q[$];
    int          model_last;
    logic [3:0]  accepted_mask;

    assign tx_busy = busy_model | busy_force;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .GAP_CYCLES(16),
        .START_TIMEOUT(1024)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= NUM; k++) begin
            if (v[(last + k) % NUM]) return (last + k) % NUM;
        end
        return -1;
    endfunction

    task automatic set_byte(input int i, input logic [7:0] d);
        req_data[i*8 +: 8] = d;
    endtask

    // UART stand-in: busy rises a few clocks after tx_start and holds for a frame.
    initial begin
        int d;
        int l;
        busy_model = 1'b0;
        forever begin
            @(negedge clock);
            if (busy_auto && reset && tx_start) begin
                d = busy_rand ? int'($urandom_range(1, 3)) : busy_dly;
                l = busy_rand ? int'($urandom_range(1, 20)) : busy_len;
                repeat (d) @(posedge clock);
                #1 busy_model = 1'b1;
                repeat (l) @(posedge clock);
                #1 busy_model = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clock) begin
        exp_t e;
        int   pick;
        if (!reset) begin
            model_last    = NUM - 1;
            accepted_mask = '0;
            exp_q.delete();
        end else begin
            if (tx_start) begin
                chk("sb_start_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_grant_id", 32'(grant_id), 32'(e.id));
                    chk("sb_tx_data", 32'(tx_data), 32'(e.data));
                end
            end
            if (tx_busy) chk("sb_ready_while_busy", 32'(req_ready), 32'd0);
            accepted_mask = req_ready & req_valid;
            if (req_ready != 4'd0) begin
                pick = model_pick(req_valid, model_last);
                chk("sb_arb_pick", 32'(req_ready), (pick < 0) ? 32'd0 : (32'd1 << pick));
                if (pick >= 0) begin
                    e.id   = pick;
                    e.data = req_data[pick*8 +: 8];
                    exp_q.push_back(e);
                    model_last = pick;
                end
            end
        end
    end

    task automatic wait_accept(output int idx);
        int n = 0;
        idx = -1;
        @(negedge clock);
        while (req_ready == 4'd0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < NUM; i++) if (req_ready[i]) idx = i;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((active || tx_busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(active | tx_busy), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        int m;
        int idx;
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};

        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        busy_force = 1'b0;
        busy_auto  = 1'b1;
        busy_rand  = 1'b0;
        busy_dly   = 2;
        busy_len   = 500;

        // Reset values, with a request already pending.
        req_valid = 4'b0001;
        set_byte(0, 8'hBE);
        @(negedge clock);
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Single byte.
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("t1_ready_immediate", 32'(req_ready), 32'b0001);
        @(posedge clock);
        #1 req_valid = '0;
        @(negedge clock);
        chk("t1_tx_start", 32'(tx_start), 32'd1);
        chk("t1_tx_data", 32'(tx_data), 32'hBE);
        chk("t1_grant_id", 32'(grant_id), 32'd0);
        chk("t1_active", 32'(active), 32'd1);
        chk("t1_ready_pulse", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("t1_start_one_cycle", 32'(tx_start), 32'd0);
        n = 0;
        while (!tx_busy && n < 100) begin @(negedge clock); n++; end
        n = 0;
        while (tx_busy && n < 2000) begin @(negedge clock); n++; end
        chk("t1_busy_fell", 32'(tx_busy), 32'd0);
        n = 0;
        while (active && n < 100) begin @(negedge clock); n++; end
        chk("t1_active_fall_delay", 32'(n), 32'd17);
        chk("t1_tx_data_held", 32'(tx_data), 32'hBE);

        // All four requesters continuously valid, after a fresh reset.
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        busy_len = 5;
        for (int i = 0; i < NUM; i++) set_byte(i, 8'h10 + 8'(i));
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            wait_accept(idx);
            if (k == 5) req_valid = '0;
            chk("t2_order", 32'(idx), 32'(exp_order[k]));
            @(negedge clock);
            chk("t2_tx_data", 32'(tx_data), 32'h10 + 32'(exp_order[k]));
        end

        // Pointer wrap: req 2 alone, then 1 and 3.
        wait_idle("t3_idle");
        set_byte(2, 8'h22);
        req_valid = 4'b0100;
        wait_accept(idx);
        chk("t3_first", 32'(idx), 32'd2);
        set_byte(1, 8'h31);
        set_byte(3, 8'h33);
        req_valid = 4'b1010;
        wait_accept(idx);
        chk("t3_second", 32'(idx), 32'd3);
        req_valid = 4'b0010;
        wait_accept(idx);
        chk("t3_third", 32'(idx), 32'd1);
        req_valid = '0;

        // Randomized traffic, including legal withdrawals before accept.
        wait_idle("rnd_idle_before");
        busy_rand = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(posedge clock);
            #1;
            req_valid = req_valid & ~accepted_mask;
            for (int i = 0; i < NUM; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    set_byte(i, 8'($urandom));
                end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        busy_rand = 1'b0;
        wait_idle("rnd_idle_after");

        // Busy never asserts: timeout, then a pending request after the gap.
        busy_auto = 1'b0;
        set_byte(0, 8'h55);
        req_valid = 4'b0001;
        wait_accept(idx);
        chk("t4_accept0", 32'(idx), 32'd0);
        set_byte(1, 8'h77);
        req_valid = 4'b0010;
        @(negedge clock);
        chk("t4_tx_start", 32'(tx_start), 32'd1);
        n = 0;
        while (!timeout_err && n < 2000) begin @(negedge clock); n++; end
        chk("t4_timeout_latency", 32'(n), 32'd1025);
        @(negedge clock);
        chk("t4_timeout_one_cycle", 32'(timeout_err), 32'd0);
        m = 1;
        while (req_ready == 4'd0 && m < 100) begin @(negedge clock); m++; end
        chk("t4_gap_then_accept", 32'(m), 32'd16);
        chk("t4_accept1", 32'(req_ready), 32'b0010);
        @(posedge clock);
        #1 req_valid = '0;
        @(negedge clock);

        // Busy high at reset release with req 0 pending.
        @(posedge clock);
        #1 reset = 1'b0;
        busy_force = 1'b1;
        set_byte(0, 8'h66);
        req_valid = 4'b0001;
        @(negedge clock);
        chk("t5_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t5_no_ready_while_busy", 32'(req_ready), 32'd0);
        end
        @(posedge clock);
        #1 busy_force = 1'b0;
        @(negedge clock);
        chk("t5_accept_same_cycle", 32'(req_ready), 32'b0001);
        @(posedge clock);
        #1 req_valid = '0;
        @(posedge clock);
        #1 busy_force = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t6_active_in_frame", 32'(active), 32'd1);
        chk("t6_tx_data_before", 32'(tx_data), 32'h66);

        // Reset asserted in WAIT_DONE, between clock edges.
        @(posedge clock);
        #1;
        set_byte(0, 8'h70);
        set_byte(3, 8'h73);
        req_valid = 4'b1001;
        #2 reset = 1'b0;
        #1;
        chk("t6_async_req_ready", 32'(req_ready), 32'd0);
        chk("t6_async_tx_start", 32'(tx_start), 32'd0);
        chk("t6_async_tx_data", 32'(tx_data), 32'd0);
        chk("t6_async_grant_id", 32'(grant_id), 32'd0);
        chk("t6_async_active", 32'(active), 32'd0);
        chk("t6_async_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("t6_wait_for_busy", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1 busy_force = 1'b0;
        wait_accept(idx);
        chk("t6_first_after_reset", 32'(idx), 32'd0);
        req_valid = 4'b1000;
        wait_accept(idx);
        chk("t6_second_after_reset", 32'(idx), 32'd3);
        req_valid = '0;
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
